// File: rtl/vga_text_pkg.sv
// Shared raster constants, VRAM field layout and pipeline stage types for the text-mode scan-out.
// Pure declarations; no timing or flow control of its own.
package vga_text_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COLS       = H_ACTIVE / 8;
    localparam int VRAM_DEPTH = 4800;
    localparam int VRAM_AW    = 13;
    localparam int VRAM_DW    = 11;
    localparam int FONT_AW    = 11;
    localparam int CNT_W      = 10;

    localparam int CHAR_LSB  = 0;
    localparam int CHAR_MSB  = 7;
    localparam int COLOR_LSB = 8;
    localparam int COLOR_MSB = 10;

    typedef logic [2:0] color_t;

    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       cursor;
        logic [2:0] x;
        logic [2:0] y;
    } s1_t;

    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       cursor;
        logic [2:0] x;
    } s2_t;

    localparam s1_t S1_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                cursor: 1'b0, x: 3'd0, y: 3'd0};
    localparam s2_t S2_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                cursor: 1'b0, x: 3'd0};

    // row*80 as two shifts so no multiplier is needed.
    function automatic logic [VRAM_AW-1:0] cell_addr(input logic [6:0] row,
                                                     input logic [6:0] col);
        logic [VRAM_AW-1:0] r;
        r = VRAM_AW'(row);
        return (r << 6) + (r << 4) + VRAM_AW'(col);
    endfunction

    function automatic logic [11:0] expand_color(input color_t c);
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
    endfunction

endpackage

// File: rtl/vga_text_reader_if.sv
// Read-side bus from the text reader to the character VRAM and the font ROM.
// Both memories answer one clk after the address; the reader never stalls them.
interface vga_text_reader_if;
    import vga_text_pkg::*;

    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_we;
    logic [VRAM_DW-1:0] vram_data;
    logic [FONT_AW-1:0] font_addr;
    logic [7:0]         font_data;

    modport master (
        output vram_addr,
        output vram_we,
        output font_addr,
        input  vram_data,
        input  font_data
    );

    modport slave (
        input  vram_addr,
        input  vram_we,
        input  font_addr,
        output vram_data,
        output font_data
    );

endinterface

// File: rtl/vga_timing.sv
// Raster counters plus raw sync/active flags; outputs are combinational from the counters.
// Advances only on pix_en_i; nothing can stall it.
module vga_timing
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FP_P     = H_FP,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_BP_P     = H_BP,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BP_P     = V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en_i,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             hsync_raw_o,
    output logic             vsync_raw_o,
    output logic             active_o,
    output logic             frame_end_o
);

    localparam int H_TOTAL_P = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int V_TOTAL_P = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL_P - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL_P - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE_P);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE_P);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE_P + H_FP_P);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE_P + H_FP_P + H_SYNC_P - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE_P + V_FP_P);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE_P + V_FP_P + V_SYNC_P - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_i) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign hsync_raw_o = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    assign vsync_raw_o = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    assign active_o    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign frame_end_o = pix_en_i && h_wrap && v_wrap;

endmodule

// File: rtl/vga_text_reader.sv
// Text-mode scan-out: raster -> VRAM cell -> font row -> RGB, 3 pix_en ticks counter-to-pin; syncs delayed to match.
// Paced purely by pix_en (no backpressure); VGA_CURSOR_EN adds a blinking inverted cursor cell.
module vga_text_reader
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FP_P     = H_FP,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_BP_P     = H_BP,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BP_P     = V_BP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pix_en,
    vga_text_reader_if.master        vbus,
    input  logic [VRAM_AW-1:0]       cursor_addr,
    output logic [11:0]              rgb,
    output logic                     hsync,
    output logic                     vsync
);

    logic [CNT_W-1:0]   h_cnt;
    logic [CNT_W-1:0]   v_cnt;
    logic               hsync_raw;
    logic               vsync_raw;
    logic               active_raw;
    logic               frame_end;
    logic [VRAM_AW-1:0] cell_c;
    logic               cursor_c;

    vga_timing #(
        .H_ACTIVE_P (H_ACTIVE_P),
        .H_FP_P     (H_FP_P),
        .H_SYNC_P   (H_SYNC_P),
        .H_BP_P     (H_BP_P),
        .V_ACTIVE_P (V_ACTIVE_P),
        .V_FP_P     (V_FP_P),
        .V_SYNC_P   (V_SYNC_P),
        .V_BP_P     (V_BP_P)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_en_i    (pix_en),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .hsync_raw_o (hsync_raw),
        .vsync_raw_o (vsync_raw),
        .active_o    (active_raw),
        .frame_end_o (frame_end)
    );

    assign cell_c = cell_addr(v_cnt[CNT_W-1:3], h_cnt[CNT_W-1:3]);

`ifdef VGA_CURSOR_EN
    logic [5:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_end) frame_cnt_d = frame_cnt_q + 6'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    // Upper half of every 64-frame period shows the cursor cell inverted.
    assign cursor_c = frame_cnt_q[5] && (cell_c == cursor_addr);
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_addr, frame_end};
    assign cursor_c      = 1'b0;
`endif

    s1_t                s1_q, s1_d;
    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
    s2_t                s2_q, s2_d;
    color_t             color_q, color_d;
    logic [FONT_AW-1:0] font_addr_q, font_addr_d;
    logic [11:0]        rgb_q, rgb_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               pixel;

    always_comb begin
        s1_d        = s1_q;
        vram_addr_d = vram_addr_q;
        s2_d        = s2_q;
        color_d     = color_q;
        font_addr_d = font_addr_q;
        rgb_d       = rgb_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        pixel       = vbus.font_data[3'd7 - s2_q.x] ^ s2_q.cursor;

        if (pix_en) begin
            s1_d = '{active: active_raw, hsync: hsync_raw, vsync: vsync_raw,
                     cursor: cursor_c, x: h_cnt[2:0], y: v_cnt[2:0]};
            // Blanking keeps the last visible cell so the address never leaves 0..4799.
            if (active_raw) vram_addr_d = cell_c;

            s2_d = '{active: s1_q.active, hsync: s1_q.hsync, vsync: s1_q.vsync,
                     cursor: s1_q.cursor, x: s1_q.x};
            color_d     = vbus.vram_data[COLOR_MSB:COLOR_LSB];
            font_addr_d = {vbus.vram_data[CHAR_MSB:CHAR_LSB], s1_q.y};

            rgb_d   = (s2_q.active && pixel) ? expand_color(color_q) : 12'h000;
            hsync_d = s2_q.hsync;
            vsync_d = s2_q.vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= S1_IDLE;
            vram_addr_q <= '0;
            s2_q        <= S2_IDLE;
            color_q     <= '0;
            font_addr_q <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            s1_q        <= s1_d;
            vram_addr_q <= vram_addr_d;
            s2_q        <= s2_d;
            color_q     <= color_d;
            font_addr_q <= font_addr_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign vbus.vram_addr = vram_addr_q;
    assign vbus.vram_we   = 1'b0;
    assign vbus.font_addr = font_addr_q;
    assign rgb            = rgb_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;

    addr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
                                    vram_addr_q < VRAM_AW'(VRAM_DEPTH));

endmodule

// File: tb/tb_vga_text_reader.sv
// Bench for vga_text_reader: a full-timing instance and a shrunk-raster instance share
// clock, reset and pix_en; a raster-arithmetic model predicts every output on every tick.
module tb_vga_text_reader;
    import vga_text_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_en = 1'b0;
    logic [12:0]       cursor_addr = 13'd81;

    logic [11:0]       rgb_o [2];
    logic              hs_o  [2];
    logic              vs_o  [2];
    logic [12:0]       va_o  [2];
    logic [10:0]       fa_o  [2];
    logic              we_o  [2];

    int tests = 0;
    int fails = 0;

    logic [10:0] vram [VRAM_DEPTH];
    logic [7:0]  font [2048];

    typedef struct {
        int ha; int hfp; int hs; int ht;
        int va; int vfp; int vs; int vt;
    } geo_t;
    geo_t geo [2];

    always #5 clk = ~clk;

    vga_text_reader_if if_full ();
    vga_text_reader_if if_small ();

    vga_text_reader u_full (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vbus(if_full),
        .cursor_addr(cursor_addr), .rgb(rgb_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0])
    );

    vga_text_reader #(
        .H_ACTIVE_P(32), .H_FP_P(4), .H_SYNC_P(8), .H_BP_P(4),
        .V_ACTIVE_P(16), .V_FP_P(2), .V_SYNC_P(2), .V_BP_P(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vbus(if_small),
        .cursor_addr(cursor_addr), .rgb(rgb_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1])
    );

    assign va_o[0] = if_full.vram_addr;
    assign va_o[1] = if_small.vram_addr;
    assign fa_o[0] = if_full.font_addr;
    assign fa_o[1] = if_small.font_addr;
    assign we_o[0] = if_full.vram_we;
    assign we_o[1] = if_small.vram_we;

    // Memories answer within one clk: latched on the falling edge, ready for the next rising edge.
    always @(negedge clk) begin
        if_full.vram_data  <= (if_full.vram_addr  < 13'(VRAM_DEPTH)) ? vram[if_full.vram_addr]  : 11'h0;
        if_small.vram_data <= (if_small.vram_addr < 13'(VRAM_DEPTH)) ? vram[if_small.vram_addr] : 11'h0;
        if_full.font_data  <= font[if_full.font_addr];
        if_small.font_data <= font[if_small.font_addr];
    end

    task automatic chk(input string name, input int k, input int j,
                       input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s dut%0d tick%0d got=%0h want=%0h", name, k, j, got, want);
        end
    endtask

    // ---- behavioural raster model ----
    function automatic int pix_h(geo_t g, int p);
        return (p % (g.ht * g.vt)) % g.ht;
    endfunction
    function automatic int pix_v(geo_t g, int p);
        return (p % (g.ht * g.vt)) / g.ht;
    endfunction
    function automatic bit pix_act(geo_t g, int p);
        return (pix_h(g, p) < g.ha) && (pix_v(g, p) < g.va);
    endfunction
    function automatic int cell_of(geo_t g, int p);
        return (pix_v(g, p) / 8) * 80 + pix_h(g, p) / 8;
    endfunction
    function automatic logic exp_hs(geo_t g, int p);
        int h;
        h = pix_h(g, p);
        return !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hs));
    endfunction
    function automatic logic exp_vs(geo_t g, int p);
        int v;
        v = pix_v(g, p);
        return !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vs));
    endfunction
    function automatic logic [11:0] exp_rgb(geo_t g, int p);
        int a;
        logic [10:0] d;
        logic [7:0]  f;
        logic        b;
        if (!pix_act(g, p)) return 12'h000;
        a = cell_of(g, p);
        d = vram[a];
        f = font[{d[7:0], 3'(pix_v(g, p) % 8)}];
        b = f[7 - pix_h(g, p) % 8];
`ifdef VGA_CURSOR_EN
        if (a == int'(cursor_addr) && ((p / (g.ht * g.vt)) % 64) >= 32) b = !b;
`endif
        return b ? {{4{d[10]}}, {4{d[9]}}, {4{d[8]}}} : 12'h000;
    endfunction

    // ---- per-tick compare process ----
    int j = 0;
    int last_a [2];
    int prev_a [2];
    int prev_y [2];
    logic [11:0] cur_blink;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                #1;
                j = 0;
                for (int k = 0; k < 2; k++) begin
                    last_a[k] = 0; prev_a[k] = 0; prev_y[k] = 0;
                    chk("rst_rgb",   k, j, 32'(rgb_o[k]), 32'h0);
                    chk("rst_hsync", k, j, 32'(hs_o[k]),  32'h1);
                    chk("rst_vsync", k, j, 32'(vs_o[k]),  32'h1);
                    chk("rst_vaddr", k, j, 32'(va_o[k]),  32'h0);
                    chk("rst_faddr", k, j, 32'(fa_o[k]),  32'h0);
                end
            end else if (pix_en) begin
                #1;
                for (int k = 0; k < 2; k++) begin
                    chk("font_addr", k, j, 32'(fa_o[k]),
                        32'({vram[prev_a[k]][7:0], 3'(prev_y[k])}));
                    if (pix_act(geo[k], j)) last_a[k] = cell_of(geo[k], j);
                    chk("vram_addr", k, j, 32'(va_o[k]), 32'(last_a[k]));
                    chk("vram_we",   k, j, 32'(we_o[k]), 32'h0);
                    prev_a[k] = last_a[k];
                    prev_y[k] = pix_v(geo[k], j) % 8;
                    if (j < 2) begin
                        chk("rgb",   k, j, 32'(rgb_o[k]), 32'h0);
                        chk("hsync", k, j, 32'(hs_o[k]),  32'h1);
                        chk("vsync", k, j, 32'(vs_o[k]),  32'h1);
                    end else begin
                        chk("rgb",   k, j, 32'(rgb_o[k]), 32'(exp_rgb(geo[k], j - 2)));
                        chk("hsync", k, j, 32'(hs_o[k]),  32'(exp_hs(geo[k], j - 2)));
                        chk("vsync", k, j, 32'(vs_o[k]),  32'(exp_vs(geo[k], j - 2)));
                    end
                end
                // Hand-computed anchors, independent of the model.
                case (j)
                    1:   chk("lit_faddr00", 0, j, 32'(fa_o[0]),  32'h208);
                    4:   chk("lit_px2",     0, j, 32'(rgb_o[0]), 32'h000);
                    5:   chk("lit_px3",     0, j, 32'(rgb_o[0]), 32'hF00);
                    6:   chk("lit_px4",     0, j, 32'(rgb_o[0]), 32'hF00);
                    7:   chk("lit_px5",     0, j, 32'(rgb_o[0]), 32'h000);
                    657: chk("lit_hs_pre",  0, j, 32'(hs_o[0]),  32'h1);
                    658: chk("lit_hs_fall", 0, j, 32'(hs_o[0]),  32'h0);
                    753: chk("lit_hs_end",  0, j, 32'(hs_o[0]),  32'h0);
                    754: chk("lit_hs_rise", 0, j, 32'(hs_o[0]),  32'h1);
                    865: chk("lit_vs_pre",  1, j, 32'(vs_o[1]),  32'h1);
                    866: chk("lit_vs_fall", 1, j, 32'(vs_o[1]),  32'h0);
                    1450: chk("lit_cur_off", 1, j, 32'(rgb_o[1]), 32'h000);
                    35242: chk("lit_cur_on", 1, j, 32'(rgb_o[1]), 32'(cur_blink));
                    default: ;
                endcase
                j++;
            end
        end
    end

    // ---- stimulus ----
    task automatic run(input int mode, input int clks);
        for (int i = 0; i < clks; i++) begin
            @(negedge clk);
            case (mode)
                0:       pix_en = !pix_en;
                1:       pix_en = 1'b1;
                default: pix_en = pix_en ? 1'b0 : ($urandom_range(0, 2) == 0);
            endcase
        end
    endtask

    initial begin
        geo[0] = '{ha: 640, hfp: 16, hs: 96, ht: 800, va: 480, vfp: 10, vs: 2, vt: 525};
        geo[1] = '{ha: 32,  hfp: 4,  hs: 8,  ht: 48,  va: 16,  vfp: 2,  vs: 2, vt: 22};
`ifdef VGA_CURSOR_EN
        cur_blink = 12'h0F0;
`else
        cur_blink = 12'h000;
`endif
        for (int i = 0; i < VRAM_DEPTH; i++) vram[i] = 11'($urandom);
        for (int i = 0; i < 2048; i++)       font[i] = 8'($urandom);
        vram[0]  = 11'h441;
        font[11'h208] = 8'h18;
        vram[81] = {3'b010, 8'h00};
        for (int r = 0; r < 8; r++) font[r] = 8'h00;

        // Model anchors: first glyph row of 'A' in red, last cell address, blanking black.
        for (int h = 0; h < 8; h++)
            chk("model_row0", 0, h, 32'(exp_rgb(geo[0], h)),
                (h == 3 || h == 4) ? 32'hF00 : 32'h000);
        chk("model_last_cell", 0, 0, 32'(cell_of(geo[0], 479 * 800 + 639)), 32'd4799);
        chk("model_blank", 0, 0, 32'(exp_rgb(geo[0], 640)), 32'h000);

        repeat (5) @(negedge clk);
        rst_n = 1'b1;

        run(0, 4000);
        run(1, 38000);

        // Asynchronous reset mid-frame: outputs must drop without waiting for a clock.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rgb",   k, -1, 32'(rgb_o[k]), 32'h0);
            chk("async_hsync", k, -1, 32'(hs_o[k]),  32'h1);
            chk("async_vsync", k, -1, 32'(vs_o[k]),  32'h1);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run(2, 8000);
        run(1, 3000);

        @(negedge clk);
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
